button_event_ctrl: RTL

Multi-button input controller that sequences the debounce/edge-detect function for `NUM_BTN` raw buttons and turns each button into a stream of press, release, long-press and auto-repeat events. A per-button event FSM generates the events. A round-robin arbiter shares a single valid/ready event port among all buttons. It sits between the board push-buttons and the user-logic command decoder, and replaces per-button edge wiring.

---
 rtl/btn_evt_pkg.sv | 28 ++
 rtl/btn_event_unit.sv | 176 +++++++++++++++++
 rtl/button_event_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the multi-button event controller.
package btn_evt_pkg;

    // Event codes as they appear on o_evt_type
    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_type_e;

    // Per-button event FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Hold counter must be able to represent the larger of the two intervals
    function automatic int cnt_width(input int long_ms, input int repeat_ms);
        return $clog2(max_int(long_ms, repeat_ms) + 1);
    endfunction

endpackage

// File: rtl/btn_event_unit.sv
// One button: 2-FF sync, tick-sampled debounce with hysteresis,
// press/release/long/repeat FSM and a single-entry pending event slot.
module btn_event_unit
    import btn_evt_pkg::*;
#(
    parameter int DEBOUNCE_MS = 8,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int CNT_W       = cnt_width(LONG_MS, REPEAT_MS)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_btn,
    input  logic      i_tick,
    input  logic      i_grant,
    output logic      o_level,
    output logic      o_pending,
    output evt_type_e o_type,
    output logic      o_drop
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    logic                   r_sync_p0;
    logic                   r_sync_p1;
    logic [DEBOUNCE_MS-1:0] r_shift;
    logic                   r_level;
    btn_state_e             r_state;
    btn_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_evt_fire;
    evt_type_e              w_evt_type;
    logic                   r_pending;
    evt_type_e              r_type;

    // Bring the raw asynchronous input into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_btn;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Debounce window: one synchronized sample enters per tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (i_tick) begin
            r_shift <= {r_shift[DEBOUNCE_MS-2:0], r_sync_p1};
        end
    end

    // Level only moves on a fully agreeing window, otherwise it holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
        end else if (&r_shift) begin
            r_level <= 1'b1;
        end else if (~|r_shift) begin
            r_level <= 1'b0;
        end
    end

    // FSM state and hold counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a falling level beats any timer expiry in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_level) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HELD: begin
                if (!r_level) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_tick) begin
                    if (r_cnt == LONG_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!r_level) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_tick) begin
                    if (r_cnt == REPEAT_LAST) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Event outputs of the FSM (Mealy: fire on the transition cycle)
    always_comb begin
        w_evt_fire = 1'b0;
        w_evt_type = EVT_PRESS;
        case (r_state)
            ST_IDLE: begin
                if (r_level) begin
                    w_evt_fire = 1'b1;
                    w_evt_type = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (!r_level) begin
                    w_evt_fire = 1'b1;
                    w_evt_type = EVT_RELEASE;
                end else if (i_tick && (r_cnt == LONG_LAST)) begin
                    w_evt_fire = 1'b1;
                    w_evt_type = EVT_LONG;
                end
            end
            ST_REPEAT: begin
                if (!r_level) begin
                    w_evt_fire = 1'b1;
                    w_evt_type = EVT_RELEASE;
                end else if (i_tick && (r_cnt == REPEAT_LAST)) begin
                    w_evt_fire = 1'b1;
                    w_evt_type = EVT_REPEAT;
                end
            end
            default: begin
                w_evt_fire = 1'b0;
                w_evt_type = EVT_PRESS;
            end
        endcase
    end

    // Pending slot: a new event always wins; a grant in the same cycle
    // sends the old entry out, so the new one stays queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_type    <= EVT_PRESS;
        end else if (w_evt_fire) begin
            r_pending <= 1'b1;
            r_type    <= w_evt_type;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    assign o_drop    = w_evt_fire & r_pending & ~i_grant;
    assign o_level   = r_level;
    assign o_pending = r_pending;
    assign o_type    = r_type;

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button event controller: tick generator, per-button event units,
// round-robin arbiter and a valid/ready output register.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int DEBOUNCE_MS = 8,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         i_btn,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] o_evt_btn,
    output logic [1:0]                 o_evt_type,
    output logic [NUM_BTN-1:0]         o_btn_level,
    output logic                       o_evt_drop
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BTN_W    = $clog2(NUM_BTN);
    localparam int CNT_W    = cnt_width(LONG_MS, REPEAT_MS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0]  r_tick_cnt;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_pending;
    logic [NUM_BTN-1:0] w_grant;
    logic [NUM_BTN-1:0] w_drop;
    logic [NUM_BTN-1:0] w_level;
    evt_type_e          w_type [NUM_BTN];
    logic               w_load_en;
    logic               w_hi_found;
    logic [BTN_W-1:0]   w_hi_idx;
    logic               w_lo_found;
    logic [BTN_W-1:0]   w_lo_idx;
    logic [BTN_W-1:0]   w_gnt_idx;
    logic               r_evt_valid;
    logic [BTN_W-1:0]   r_evt_btn;
    evt_type_e          r_evt_type;
    logic [BTN_W-1:0]   r_last_grant;
    logic               r_drop;

    // Free-running divider; tick is high for the terminal-count cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            assign w_grant[g] = w_load_en && w_lo_found && (w_gnt_idx == BTN_W'(g));

            btn_event_unit #(
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .LONG_MS     (LONG_MS),
                .REPEAT_MS   (REPEAT_MS),
                .CNT_W       (CNT_W)
            ) u_unit (
                .clk       (clk),
                .reset     (reset),
                .i_btn     (i_btn[g]),
                .i_tick    (w_tick),
                .i_grant   (w_grant[g]),
                .o_level   (w_level[g]),
                .o_pending (w_pending[g]),
                .o_type    (w_type[g]),
                .o_drop    (w_drop[g])
            );
        end
    endgenerate

    // Round robin: lowest pending index above last_grant, else lowest overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (w_pending[k]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = BTN_W'(k);
                if (BTN_W'(k) > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = BTN_W'(k);
                end
            end
        end
    end

    assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_load_en = !r_evt_valid || i_evt_ready;

    // Output register: reload whenever the consumer side is free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_valid  <= 1'b0;
            r_evt_btn    <= '0;
            r_evt_type   <= EVT_PRESS;
            r_last_grant <= BTN_W'(NUM_BTN - 1);
        end else if (w_load_en) begin
            if (w_lo_found) begin
                r_evt_valid  <= 1'b1;
                r_evt_btn    <= w_gnt_idx;
                r_evt_type   <= w_type[w_gnt_idx];
                r_last_grant <= w_gnt_idx;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    // Registered overwrite indication from any button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= |w_drop;
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_btn   = r_evt_btn;
    assign o_evt_type  = r_evt_type;
    assign o_btn_level = w_level;
    assign o_evt_drop  = r_drop;

endmodule
